acc_dec: RTL and testbench
==========================

Name: acc_dec

Overview:
- Decoder for the accumulator output stream. Accepts successive W-bit accumulator samples and recovers the per-cycle step magnitude and direction that produced each one.
- Recovery uses modular differencing against the previous sample.
- Sits on the monitor side of the accumulator. Flags any sample pair whose difference cannot come from a single legal step.

Parameters:
- W, 8, accumulator sample width.
- BW, 3, step magnitude width. Max legal step is 2^BW-1 (7 by default).

Ports:
- clk  input  1  clock, rising-edge active.
- r  input  1  synchronous active-high reset.
- y_in  input  W  accumulator sample.
- y_valid  input  1  y_in is valid this cycle; sampled at the clk edge.
- resync  input  1  drop the reference sample and leave FAULT; synchronous.
- b_out  output  BW  recovered step magnitude.
- sel_out  output  1  recovered direction: 0 = add, 1 = subtract.
- out_valid  output  1  one-cycle pulse; b_out/sel_out are valid.
- err  output  1  sticky fault flag.
- err_cnt  output  8  fault entry count (see Optional Feature).

Behaviour:
- All outputs are registered. Priority: r > resync > y_valid.
- Reset (r=1 at clk edge):
  - state=EMPTY, prev=0, b_out=0, sel_out=0, out_valid=0, err=0, err_cnt=0.
- States:
  - EMPTY: no reference sample held.
  - TRACK: reference held; decoding.
  - FAULT: illegal difference seen; stalled.
- d = (y_in - prev) mod 2^W. Unsigned W-bit subtraction; the borrow is discarded.
- EMPTY + y_valid:
  - prev<=y_in; go to TRACK; out_valid stays 0.
  - The first sample is reference only and produces no output.
- TRACK + y_valid, one of three cases:
  - d <= 2^BW-1: b_out<=d[BW-1:0], sel_out<=0, out_valid<=1.
  - d >= 2^W-(2^BW-1): b_out<=(2^W-d)[BW-1:0], sel_out<=1, out_valid<=1.
  - Otherwise: out_valid<=0, err<=1, go to FAULT.
  - In all three cases prev<=y_in.
- d=0 decodes as b_out=0, sel_out=0 (add; hold is indistinguishable from add-zero).
- Latency: the decoded result appears exactly 1 clk after the sample edge. out_valid is high for one cycle only, unless valid samples arrive back-to-back.
- b_out/sel_out hold their last decoded value when out_valid=0.
- FAULT:
  - y_valid is ignored and prev is frozen; out_valid=0; err stays 1.
  - Only resync or r leaves FAULT.
- resync (any state): go to EMPTY, err<=0, out_valid<=0. b_out/sel_out are held.
- resync and y_valid in the same cycle: resync wins and the sample is discarded.
- Wrap-around is legal and decodes as a normal step:
  - 250 -> 0: d=6, sel=0, b=6.
  - 3 -> 254: d=251, sel=1, b=5.
- Reset mid-stream discards the reference. The next sample after reset is reference-only.
- y_valid=0 in any state: no state change; out_valid<=0.

Optional Feature:
- Macro: ACC_DEC_ERRCNT_EN.
- Defined:
  - err_cnt increments by 1 on each TRACK->FAULT transition and saturates at 255.
  - It is cleared only by r; resync does not clear it.
- Undefined:
  - err_cnt is tied to 0 and no counter register is built.
  - The port still exists, so instantiations are identical in both builds.

Test Plan:
- T1, reset and reference: r=1 for 3 cycles, then y_valid with y_in=0 -> all outputs 0; no out_valid on the reference sample.
- T2, add steps: samples 0,3,7,13 -> out_valid pulses with b_out=3,4,6 and sel_out=0. Each pulse is 1 clk after its sample.
- T3, subtract and wrap:
  - 13,7 -> b=6, sel=1.
  - 250,0 -> b=6, sel=0.
  - 3,254 -> b=5, sel=1.
- T4, fault: 10 then 250 (d=240) -> err=1, out_valid=0, FAULT. Further samples are ignored. Then resync -> err=0, EMPTY. Then 20,22 -> b=2, sel=0.
- T5, collisions:
  - resync with y_valid=1 -> sample dropped, next sample is reference.
  - r asserted in FAULT -> err=0, EMPTY.
- T6, ACC_DEC_ERRCNT_EN:
  - Defined: 3 faults separated by resync -> err_cnt=3; resync leaves it at 3; r clears it to 0.
  - Undefined: err_cnt=0 throughout.

Source files
------------

// File: rtl/acc_dec.sv
// acc_dec: decodes a stream of W-bit accumulator samples back into the
// per-cycle step magnitude (b_out) and direction (sel_out, 1 = subtract).
// Each sample is differenced modulo 2^W against the previous one. A
// difference that no single step of at most 2^BW-1 can explain latches
// a sticky fault until resync or reset.
// Optional build macro: ACC_DEC_ERRCNT_EN. When it is defined, err_cnt
// counts entries into FAULT and saturates at 255. Without it, err_cnt
// reads 0 and no counter register exists.
module acc_dec #(
   parameter int W  = 8,
   parameter int BW = 3
) (
   input  logic          clk,
   input  logic          r,
   input  logic [W-1:0]  y_in,
   input  logic          y_valid,
   input  logic          resync,
   output logic [BW-1:0] b_out,
   output logic          sel_out,
   output logic          out_valid,
   output logic          err,
   output logic [7:0]    err_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      TRACK = 2'd1,
      FAULT = 2'd2
   } state_t;

   // Largest legal step magnitude, widened to the sample width for compares.
   localparam logic [W-1:0] MAX_STEP = W'((2 ** BW) - 1);

   state_t        state_q, state_d;
   logic [W-1:0]  prev_q, prev_d;
   logic [BW-1:0] b_q, b_d;
   logic          sel_q, sel_d;
   logic          ov_q, ov_d;
   logic          err_q, err_d;

   logic [W-1:0]  diff;
   logic [W-1:0]  neg_diff;

   // Forward and backward modular distance from the reference sample.
   // The borrow out of the subtraction is intentionally discarded.
   always_comb begin
      diff     = y_in - prev_q;
      neg_diff = '0 - diff;
   end

   // Next-state, reference and decoded-output computation.
   always_comb begin
      state_d = state_q;
      prev_d  = prev_q;
      b_d     = b_q;
      sel_d   = sel_q;
      ov_d    = 1'b0;
      err_d   = err_q;
      if (resync) begin
         // A sample that arrives with resync is dropped with the reference.
         state_d = EMPTY;
         err_d   = 1'b0;
      end else if (y_valid) begin
         unique case (state_q)
            EMPTY: begin
               prev_d  = y_in;
               state_d = TRACK;
            end
            TRACK: begin
               prev_d = y_in;
               if (diff <= MAX_STEP) begin
                  // Zero difference also lands here and decodes as add-zero.
                  b_d   = diff[BW-1:0];
                  sel_d = 1'b0;
                  ov_d  = 1'b1;
               end else if (neg_diff <= MAX_STEP) begin
                  b_d   = neg_diff[BW-1:0];
                  sel_d = 1'b1;
                  ov_d  = 1'b1;
               end else begin
                  err_d   = 1'b1;
                  state_d = FAULT;
               end
            end
            FAULT: begin
               // Stalled: samples are ignored and the reference stays frozen.
            end
            default: begin
               state_d = EMPTY;
            end
         endcase
      end
   end

   // Register all state and outputs; reset dominates everything.
   always_ff @(posedge clk) begin
      if (r) begin
         state_q <= EMPTY;
         prev_q  <= '0;
         b_q     <= '0;
         sel_q   <= 1'b0;
         ov_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         prev_q  <= prev_d;
         b_q     <= b_d;
         sel_q   <= sel_d;
         ov_q    <= ov_d;
         err_q   <= err_d;
      end
   end

`ifdef ACC_DEC_ERRCNT_EN
   logic [7:0] err_cnt_q, err_cnt_d;
   logic       to_fault;

   // Count TRACK->FAULT entries, saturating; resync does not clear it.
   always_comb begin
      to_fault  = (state_q == TRACK) && (state_d == FAULT);
      err_cnt_d = err_cnt_q;
      if (to_fault && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   // Fault counter register, cleared only by reset.
   always_ff @(posedge clk) begin
      if (r) begin
         err_cnt_q <= 8'd0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_cnt = err_cnt_q;
`else
   assign err_cnt = 8'd0;
`endif

   assign b_out     = b_q;
   assign sel_out   = sel_q;
   assign out_valid = ov_q;
   assign err       = err_q;

endmodule

// File: tb/tb_acc_dec.sv
// Directed testbench for acc_dec. The expected values are worked out by hand
// from the decoding rules. The err_cnt expectations follow ACC_DEC_ERRCNT_EN.
module tb_acc_dec;

   logic       clk;
   logic       r;
   logic [7:0] y_in;
   logic       y_valid;
   logic       resync;
   logic [2:0] b_out;
   logic       sel_out;
   logic       out_valid;
   logic       err;
   logic [7:0] err_cnt;

   int n_assert;
   int n_fail;

`ifdef ACC_DEC_ERRCNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   acc_dec #(.W(8), .BW(3)) dut (
      .clk       (clk),
      .r         (r),
      .y_in      (y_in),
      .y_valid   (y_valid),
      .resync    (resync),
      .b_out     (b_out),
      .sel_out   (sel_out),
      .out_valid (out_valid),
      .err       (err),
      .err_cnt   (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs at the falling edge, then settle past the rising edge.
   task automatic cyc(input logic v, input logic [7:0] y, input logic rs, input logic rr);
      @(negedge clk);
      y_valid = v;
      y_in    = y;
      resync  = rs;
      r       = rr;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic ov, input logic [2:0] b,
                          input logic s, input logic e);
      check({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
      check({tag, ".b_out"},     32'(b_out),     32'(b));
      check({tag, ".sel_out"},   32'(sel_out),   32'(s));
      check({tag, ".err"},       32'(err),       32'(e));
   endtask

   task automatic chk_cnt(input string tag, input logic [7:0] n);
      check({tag, ".err_cnt"}, 32'(err_cnt), CNT_EN ? 32'(n) : 32'd0);
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      r        = 1'b1;
      y_in     = 8'd0;
      y_valid  = 1'b0;
      resync   = 1'b0;

      // T1: reset and reference sample.
      cyc(1'b0, 8'd0, 1'b0, 1'b1);
      cyc(1'b0, 8'd0, 1'b0, 1'b1);
      cyc(1'b1, 8'd99, 1'b0, 1'b1);
      chk_out("t1_reset", 1'b0, 3'd0, 1'b0, 1'b0);
      chk_cnt("t1_reset", 8'd0);
      cyc(1'b1, 8'd0, 1'b0, 1'b0);
      chk_out("t1_ref", 1'b0, 3'd0, 1'b0, 1'b0);

      // T2: add steps 0->3->7->13.
      cyc(1'b1, 8'd3, 1'b0, 1'b0);
      chk_out("t2_add3", 1'b1, 3'd3, 1'b0, 1'b0);
      cyc(1'b1, 8'd7, 1'b0, 1'b0);
      chk_out("t2_add4", 1'b1, 3'd4, 1'b0, 1'b0);
      cyc(1'b1, 8'd13, 1'b0, 1'b0);
      chk_out("t2_add6", 1'b1, 3'd6, 1'b0, 1'b0);
      cyc(1'b0, 8'd200, 1'b0, 1'b0);
      chk_out("t2_idle_hold", 1'b0, 3'd6, 1'b0, 1'b0);

      // T3: subtract and wrap-around.
      cyc(1'b1, 8'd7, 1'b0, 1'b0);
      chk_out("t3_sub6", 1'b1, 3'd6, 1'b1, 1'b0);
      cyc(1'b0, 8'd0, 1'b1, 1'b0);
      chk_out("t3_resync_hold", 1'b0, 3'd6, 1'b1, 1'b0);
      cyc(1'b1, 8'd250, 1'b0, 1'b0);
      chk_out("t3_ref250", 1'b0, 3'd6, 1'b1, 1'b0);
      cyc(1'b1, 8'd0, 1'b0, 1'b0);
      chk_out("t3_wrap_up", 1'b1, 3'd6, 1'b0, 1'b0);
      cyc(1'b1, 8'd3, 1'b0, 1'b0);
      chk_out("t3_add3", 1'b1, 3'd3, 1'b0, 1'b0);
      cyc(1'b1, 8'd254, 1'b0, 1'b0);
      chk_out("t3_wrap_down", 1'b1, 3'd5, 1'b1, 1'b0);

      // T4: fault, ignored samples, resync, recovery, zero step.
      cyc(1'b0, 8'd0, 1'b1, 1'b0);
      cyc(1'b1, 8'd10, 1'b0, 1'b0);
      chk_out("t4_ref10", 1'b0, 3'd5, 1'b1, 1'b0);
      cyc(1'b1, 8'd250, 1'b0, 1'b0);
      chk_out("t4_fault", 1'b0, 3'd5, 1'b1, 1'b1);
      chk_cnt("t4_fault", 8'd1);
      cyc(1'b1, 8'd12, 1'b0, 1'b0);
      chk_out("t4_ignored", 1'b0, 3'd5, 1'b1, 1'b1);
      cyc(1'b0, 8'd0, 1'b1, 1'b0);
      chk_out("t4_resync", 1'b0, 3'd5, 1'b1, 1'b0);
      chk_cnt("t4_resync", 8'd1);
      cyc(1'b1, 8'd20, 1'b0, 1'b0);
      chk_out("t4_ref20", 1'b0, 3'd5, 1'b1, 1'b0);
      cyc(1'b1, 8'd22, 1'b0, 1'b0);
      chk_out("t4_add2", 1'b1, 3'd2, 1'b0, 1'b0);
      cyc(1'b1, 8'd22, 1'b0, 1'b0);
      chk_out("t4_zero", 1'b1, 3'd0, 1'b0, 1'b0);

      // T5: resync colliding with a sample, then reset while in FAULT.
      cyc(1'b1, 8'd100, 1'b1, 1'b0);
      chk_out("t5_collide", 1'b0, 3'd0, 1'b0, 1'b0);
      cyc(1'b1, 8'd105, 1'b0, 1'b0);
      chk_out("t5_ref105", 1'b0, 3'd0, 1'b0, 1'b0);
      cyc(1'b1, 8'd107, 1'b0, 1'b0);
      chk_out("t5_add2", 1'b1, 3'd2, 1'b0, 1'b0);
      cyc(1'b1, 8'd200, 1'b0, 1'b0);
      chk_out("t5_fault", 1'b0, 3'd2, 1'b0, 1'b1);
      chk_cnt("t5_fault", 8'd2);
      cyc(1'b1, 8'd201, 1'b0, 1'b1);
      chk_out("t5_reset_fault", 1'b0, 3'd0, 1'b0, 1'b0);
      chk_cnt("t5_reset_fault", 8'd0);

      // Boundary steps: +7 and -7 legal, +8 illegal.
      cyc(1'b1, 8'd50, 1'b0, 1'b0);
      chk_out("bnd_ref50", 1'b0, 3'd0, 1'b0, 1'b0);
      cyc(1'b1, 8'd57, 1'b0, 1'b0);
      chk_out("bnd_add7", 1'b1, 3'd7, 1'b0, 1'b0);
      cyc(1'b1, 8'd50, 1'b0, 1'b0);
      chk_out("bnd_sub7", 1'b1, 3'd7, 1'b1, 1'b0);
      cyc(1'b1, 8'd58, 1'b0, 1'b0);
      chk_out("bnd_add8", 1'b0, 3'd7, 1'b1, 1'b1);
      chk_cnt("bnd_add8", 8'd1);
      cyc(1'b0, 8'd0, 1'b1, 1'b0);
      cyc(1'b1, 8'd58, 1'b0, 1'b0);
      cyc(1'b1, 8'd50, 1'b0, 1'b0);
      chk_out("bnd_sub8", 1'b0, 3'd7, 1'b1, 1'b1);
      chk_cnt("bnd_sub8", 8'd2);

      // T6: further faults separated by resync, then reset clears the count.
      cyc(1'b0, 8'd0, 1'b1, 1'b0);
      cyc(1'b1, 8'd0, 1'b0, 1'b0);
      cyc(1'b1, 8'd100, 1'b0, 1'b0);
      chk_cnt("t6_fault3", 8'd3);
      cyc(1'b0, 8'd0, 1'b1, 1'b0);
      chk_out("t6_resync", 1'b0, 3'd7, 1'b1, 1'b0);
      chk_cnt("t6_resync", 8'd3);
      cyc(1'b0, 8'd0, 1'b0, 1'b1);
      chk_cnt("t6_reset", 8'd0);
      chk_out("t6_reset", 1'b0, 3'd0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
